// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: control from hazard/branch logic, instruction memory port, IF/ID register outputs.
interface instruction_fetch_unit_if #(
  parameter int PC_WIDTH = 32
);
  logic                Stall;
  logic                Flush;
  logic                Branch_taken;
  logic [PC_WIDTH-1:0] Branch_target;
  logic [31:0]         Instruction_in;
  logic [PC_WIDTH-1:0] PC_out;
  logic [31:0]         IF_ID_Instruction;
  logic [PC_WIDTH-1:0] IF_ID_PC_plus4;
  logic                IF_ID_valid;
  logic                Halted;

  modport master (
    output Stall, Flush, Branch_taken, Branch_target, Instruction_in,
    input  PC_out, IF_ID_Instruction, IF_ID_PC_plus4, IF_ID_valid, Halted
  );

  modport slave (
    input  Stall, Flush, Branch_taken, Branch_target, Instruction_in,
    output PC_out, IF_ID_Instruction, IF_ID_PC_plus4, IF_ID_valid, Halted
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, drives combinational instruction memory, fills the IF/ID register.
module instruction_fetch_unit #(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter bit                  HALT_ON_ZERO = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  instruction_fetch_unit_if.slave  bus
);
  typedef enum logic {RUN, HALT} state_t;

  state_t              state;
  logic                halted;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] br_pc;
  logic [31:0]         if_instr;
  logic [PC_WIDTH-1:0] if_pc4;
  logic                if_vld;
  logic                zero_word;

  // Natural wrap of the adder gives modulo-2^PC_WIDTH PC arithmetic.
  assign pc_plus4  = pc + PC_WIDTH'(4);
  assign br_pc     = {bus.Branch_target[PC_WIDTH-1:2], 2'b00};
  assign zero_word = HALT_ON_ZERO && (bus.Instruction_in == 32'h0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      if_instr <= '0;
      if_pc4   <= '0;
      if_vld   <= 1'b0;
      state    <= RUN;
      halted   <= 1'b0;
    end else if (bus.Branch_taken) begin
      pc       <= br_pc;
      if_instr <= '0;
      if_pc4   <= '0;
      if_vld   <= 1'b0;
      state    <= RUN;
      halted   <= 1'b0;
    end else if (state == HALT) begin
      if_instr <= '0;
      if_pc4   <= '0;
      if_vld   <= 1'b0;
    end else if (bus.Stall) begin
      // Stall freezes PC and IF/ID; a concurrent Flush still kills the held entry.
      if (bus.Flush) begin
        if_instr <= '0;
        if_pc4   <= '0;
        if_vld   <= 1'b0;
      end
    end else if (bus.Flush) begin
      pc       <= pc_plus4;
      if_instr <= '0;
      if_pc4   <= '0;
      if_vld   <= 1'b0;
    end else if (zero_word) begin
      // End-of-program word: park on it and never forward it to ID.
      state    <= HALT;
      halted   <= 1'b1;
      if_instr <= '0;
      if_pc4   <= '0;
      if_vld   <= 1'b0;
    end else begin
      pc       <= pc_plus4;
      if_instr <= bus.Instruction_in;
      if_pc4   <= pc_plus4;
      if_vld   <= 1'b1;
    end
  end

  assign bus.PC_out            = pc;
  assign bus.IF_ID_Instruction = if_instr;
  assign bus.IF_ID_PC_plus4    = if_pc4;
  assign bus.IF_ID_valid       = if_vld;
  assign bus.Halted            = halted;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed scoreboard bench for instruction_fetch_unit: default instance plus a wrap/no-halt instance.
module tb_instruction_fetch_unit;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic [31:0] instr_b;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          sel;
    string       tag;
    logic [31:0] pc, instr, pc4;
    logic        vld, hlt;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.PC_WIDTH(32)) ifa ();
  instruction_fetch_unit_if #(.PC_WIDTH(32)) ifb ();

  instruction_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0), .HALT_ON_ZERO(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa.slave));
  instruction_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .HALT_ON_ZERO(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb.slave));

  // Program: words 0..6 nonzero, word 7 is the end-of-program zero.
  function automatic logic [31:0] word(input int i);
    return (i >= 7) ? 32'h0 : 32'h0001_1000 * (i + 1);
  endfunction

  assign ifa.Instruction_in = word(int'(ifa.PC_out[4:2]));
  assign ifb.Instruction_in = instr_b;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected post-edge state, then compare after the edge.
  task automatic step(input bit sel, input string tag, input logic r, input logic st, input logic fl,
                      input logic br, input logic [31:0] bt, input logic [31:0] epc,
                      input logic [31:0] ei, input logic [31:0] ep4, input logic ev, input logic eh);
    exp_t e;
    if (!sel) begin
      rst_a = r; ifa.Stall = st; ifa.Flush = fl; ifa.Branch_taken = br; ifa.Branch_target = bt;
    end else begin
      rst_b = r; ifb.Stall = st; ifb.Flush = fl; ifb.Branch_taken = br; ifb.Branch_target = bt;
    end
    e.sel = sel; e.tag = tag; e.pc = epc; e.instr = ei; e.pc4 = ep4; e.vld = ev; e.hlt = eh;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (!e.sel) begin
      chk({e.tag, ".pc"},    ifa.PC_out,            e.pc);
      chk({e.tag, ".instr"}, ifa.IF_ID_Instruction, e.instr);
      chk({e.tag, ".pc4"},   ifa.IF_ID_PC_plus4,    e.pc4);
      chk({e.tag, ".vld"},   32'(ifa.IF_ID_valid),  32'(e.vld));
      chk({e.tag, ".hlt"},   32'(ifa.Halted),       32'(e.hlt));
    end else begin
      chk({e.tag, ".pc"},    ifb.PC_out,            e.pc);
      chk({e.tag, ".instr"}, ifb.IF_ID_Instruction, e.instr);
      chk({e.tag, ".pc4"},   ifb.IF_ID_PC_plus4,    e.pc4);
      chk({e.tag, ".vld"},   32'(ifb.IF_ID_valid),  32'(e.vld));
      chk({e.tag, ".hlt"},   32'(ifb.Halted),       32'(e.hlt));
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; instr_b = 32'h0;
    ifa.Stall = 0; ifa.Flush = 0; ifa.Branch_taken = 0; ifa.Branch_target = '0;
    ifb.Stall = 0; ifb.Flush = 0; ifb.Branch_taken = 0; ifb.Branch_target = '0;
    @(posedge clk); #1;

    // 1: reset, sequential fetch, halt on word 7
    step(0, "rst",  1, 0, 0, 0, 0, 32'd0, 32'h0, 32'd0, 0, 0);
    for (int k = 1; k <= 7; k++)
      step(0, $sformatf("run%0d", k), 0, 0, 0, 0, 0, 32'(4*k), word(k-1), 32'(4*k), 1, 0);
    step(0, "halt0", 0, 0, 0, 0, 0, 32'd28, 32'h0, 32'd0, 0, 1);
    step(0, "halt1", 0, 0, 0, 0, 0, 32'd28, 32'h0, 32'd0, 0, 1);

    // 4: stall/flush ignored in HALT; branch leaves HALT
    step(0, "haltsf", 0, 1, 1, 0, 0, 32'd28, 32'h0, 32'd0, 0, 1);
    step(0, "hbr",    0, 0, 0, 1, 32'h0, 32'd0, 32'h0, 32'd0, 0, 0);
    step(0, "hbr_w0", 0, 0, 0, 0, 0, 32'd4, word(0), 32'd4, 1, 0);
    step(0, "to8",    0, 0, 0, 0, 0, 32'd8, word(1), 32'd8, 1, 0);

    // 2: stall three cycles at PC 8
    for (int k = 0; k < 3; k++)
      step(0, $sformatf("stall%0d", k), 0, 1, 0, 0, 0, 32'd8, word(1), 32'd8, 1, 0);
    step(0, "unstall", 0, 0, 0, 0, 0, 32'd12, word(2), 32'd12, 1, 0);

    // 3: branch beats stall; target low bits dropped
    step(0, "brstall", 0, 1, 0, 1, 32'h6, 32'd4, 32'h0, 32'd0, 0, 0);
    step(0, "br_w1",   0, 0, 0, 0, 0, 32'd8, word(1), 32'd8, 1, 0);
    step(0, "to12",    0, 0, 0, 0, 0, 32'd12, word(2), 32'd12, 1, 0);
    step(0, "to16",    0, 0, 0, 0, 0, 32'd16, word(3), 32'd16, 1, 0);

    // 5: flush+stall holds PC with bubble; flush alone advances
    step(0, "flst",  0, 1, 1, 0, 0, 32'd16, 32'h0, 32'd0, 0, 0);
    step(0, "flush", 0, 0, 1, 0, 0, 32'd20, 32'h0, 32'd0, 0, 0);

    // 6a: reset wins over stall
    step(0, "rststall", 1, 1, 0, 0, 0, 32'd0, 32'h0, 32'd0, 0, 0);
    step(0, "post_rst", 0, 0, 0, 0, 0, 32'd4, word(0), 32'd4, 1, 0);

    // reset wins while halted
    step(0, "br1f",   0, 0, 0, 1, 32'h1F, 32'd28, 32'h0, 32'd0, 0, 0);
    step(0, "halt2",  0, 0, 0, 0, 0, 32'd28, 32'h0, 32'd0, 0, 1);
    step(0, "rsthlt", 1, 0, 0, 0, 0, 32'd0, 32'h0, 32'd0, 0, 0);

    // 6b: wrap from max PC; zero word is an ordinary instruction
    step(1, "b_rst", 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'd0, 0, 0);
    instr_b = 32'h1234_5678;
    step(1, "b_wrap", 0, 0, 0, 0, 0, 32'd0, 32'h1234_5678, 32'd0, 1, 0);
    instr_b = 32'h0;
    step(1, "b_zero", 0, 0, 0, 0, 0, 32'd4, 32'h0, 32'd4, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
